// File: rtl/yuv_pkg.sv
// Shared definitions for the YUV420 frame-compare sequencer.
// Provides the frame-geometry helpers, the geometry of the default
// 1280x720 frame, the FSM state encoding and the plane indices.
// Modules built for another geometry compute their own values with the
// same helpers.
package yuv_pkg;

    // Bytes in the Y plane.
    function automatic int unsigned luma_bytes(int unsigned w, int unsigned h);
        return w * h;
    endfunction

    // Bytes in each chroma plane of a 4:2:0 frame.
    function automatic int unsigned chroma_bytes(int unsigned w, int unsigned h);
        return (w * h) / 4;
    endfunction

    // Bytes in a whole frame: Y + U + V.
    function automatic int unsigned frame_bytes(int unsigned w, int unsigned h);
        return (w * h * 3) / 2;
    endfunction

    localparam int unsigned DEF_WIDTH  = 1280;
    localparam int unsigned DEF_HEIGHT = 720;

    localparam int unsigned Y_BYTES = luma_bytes(DEF_WIDTH, DEF_HEIGHT);
    localparam int unsigned C_BYTES = chroma_bytes(DEF_WIDTH, DEF_HEIGHT);
    localparam int unsigned FRAME   = frame_bytes(DEF_WIDTH, DEF_HEIGHT);
    localparam int unsigned U_BASE  = Y_BYTES;
    localparam int unsigned V_BASE  = Y_BYTES + C_BYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PL_Y = 2'd0,
        PL_U = 2'd1,
        PL_V = 2'd2
    } plane_e;

endpackage

// File: rtl/yuv_addr_gen.sv
// Frame address generator for the compare sequencer.
// Counts byte addresses from 0 up to FRAME_BYTES-1 and flags the last one.
// It also decodes which plane an address belongs to. The counter stops
// at the last address; the sequencer leaves RUN once that address is issued.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       load address 0 (start of a run)
//   en          advance to the next address (a read was issued)
//   addr        current address to issue
//   last        addr is the final byte of the frame
//   cmp_addr    address to classify (the one being compared)
//   cmp_plane   plane of cmp_addr
module yuv_addr_gen
    import yuv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned FRAME_BYTES = FRAME,
    parameter int unsigned U_START     = U_BASE,
    parameter int unsigned V_START     = V_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    input  logic [ADDR_W-1:0] cmp_addr,
    output plane_e            cmp_plane
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_W-1:0] U_ADDR    = ADDR_W'(U_START);
    localparam logic [ADDR_W-1:0] V_ADDR    = ADDR_W'(V_START);

    assign last = (addr == LAST_ADDR);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    always_comb begin
        if (cmp_addr < U_ADDR) begin
            cmp_plane = PL_Y;
        end else if (cmp_addr < V_ADDR) begin
            cmp_plane = PL_U;
        end else begin
            cmp_plane = PL_V;
        end
    end

endmodule

// File: rtl/yuv_cmp_ctrl.sv
// YUV420 frame-compare sequencer.
// On start, it walks every byte of one frame through a shared read
// address to the golden and DUT BRAMs. It compares the bytes returned
// one cycle later and accumulates the error count, the first mismatch
// address and sticky per-plane error flags. done pulses once the last
// compare has landed in the statistics.
//
// Build option: define YUV_CMP_EARLY_STOP_EN to end the scan at the first
// mismatch. A read issued in the detecting cycle is still compared.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle request to begin a compare (ignored when busy)
//   pause            suppresses new reads while high
//   busy             run in progress
//   done             one-cycle completion pulse
//   rd_en, rd_addr   shared BRAM read port (rd_addr holds when idle)
//   rd_data_a/b      golden / DUT BRAM data, valid one cycle after rd_en
//   err_cnt          saturating mismatch count
//   first_err_vld    a mismatch was seen this run
//   first_err_addr   address of the first mismatch
//   plane_err        sticky {V,U,Y} mismatch flags
module yuv_cmp_ctrl
    import yuv_pkg::*;
#(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 720,
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [ADDR_W-1:0] err_cnt,
    output logic              first_err_vld,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [2:0]        plane_err
);

    localparam int unsigned L_FRAME  = frame_bytes(WIDTH, HEIGHT);
    localparam int unsigned L_U_BASE = luma_bytes(WIDTH, HEIGHT);
    localparam int unsigned L_V_BASE = luma_bytes(WIDTH, HEIGHT) + chroma_bytes(WIDTH, HEIGHT);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              accept;
    logic              pipe_vld;
    logic [ADDR_W-1:0] pipe_addr;
    logic              mismatch;
    logic              early_stop;
    plane_e            cmp_plane;

    yuv_addr_gen #(
        .ADDR_W      (ADDR_W),
        .FRAME_BYTES (L_FRAME),
        .U_START     (L_U_BASE),
        .V_START     (L_V_BASE)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .en        (rd_en),
        .addr      (addr),
        .last      (last),
        .cmp_addr  (pipe_addr),
        .cmp_plane (cmp_plane)
    );

    assign accept   = (state == IDLE) && start;
    // pipe_vld is only ever set by a read issued in RUN, so data arriving
    // in any other cycle never reaches the statistics.
    assign mismatch = pipe_vld && (rd_data_a != rd_data_b);

`ifdef YUV_CMP_EARLY_STOP_EN
    assign early_stop = mismatch && !first_err_vld;
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                rd_en = ~pause;
                if ((rd_en && last) || early_stop) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The registered copy of the last issued address doubles as the held
    // read address while no read is issued.
    assign rd_addr = rd_en ? addr : pipe_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld  <= 1'b0;
            pipe_addr <= '0;
        end else begin
            pipe_vld <= rd_en;
            if (rd_en) pipe_addr <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
            plane_err      <= '0;
        end else if (accept) begin
            err_cnt        <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
            plane_err      <= '0;
        end else if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ADDR_W'(1);
            if (!first_err_vld) begin
                first_err_vld  <= 1'b1;
                first_err_addr <= pipe_addr;
            end
            case (cmp_plane)
                PL_Y:    plane_err[0] <= 1'b1;
                PL_U:    plane_err[1] <= 1'b1;
                PL_V:    plane_err[2] <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_yuv_cmp_ctrl.sv
// Self-checking bench for yuv_cmp_ctrl on an 8x4 frame (48 bytes:
// Y 0-31, U 32-39, V 40-47). Two behavioural BRAMs feed the DUT. A
// reference model tracks the frame walk as counts of issued and pending
// reads and computes the statistics from the image contents. A
// negedge compare process checks every output each cycle. Directed
// tests also pin literal results. Define YUV_CMP_EARLY_STOP_EN for
// the early-stop build.
module tb_yuv_cmp_ctrl;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int FRAME = W * H * 3 / 2;
    localparam int U_ST  = W * H;
    localparam int V_ST  = W * H + W * H / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          busy, done, rd_en, first_err_vld;
    logic [AW-1:0] rd_addr, err_cnt, first_err_addr;
    logic [DW-1:0] q_a, q_b;
    logic [2:0]    plane_err;

    logic [7:0] mem_a [FRAME];
    logic [7:0] mem_b [FRAME];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    yuv_cmp_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pause          (pause),
        .busy           (busy),
        .done           (done),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data_a      (q_a),
        .rd_data_b      (q_b),
        .err_cnt        (err_cnt),
        .first_err_vld  (first_err_vld),
        .first_err_addr (first_err_addr),
        .plane_err      (plane_err)
    );

    // BRAM pair; unrequested cycles return unequal noise that must be ignored.
    always @(posedge clk) begin
        if (rd_en) begin
            q_a <= mem_a[rd_addr];
            q_b <= mem_b[rd_addr];
        end else begin
            q_a <= 8'($urandom);
            q_b <= ~q_a;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_busy, m_stopped, m_pend, m_fv, m_en;
    int       m_issued, m_fin, m_last, m_pend_addr, m_err, m_fa;
    bit [2:0] m_pl;

    function automatic int plane_of(input int a);
        if (a < U_ST) return 0;
        if (a < V_ST) return 1;
        return 2;
    endfunction

    function automatic bit exp_rd_en();
        return m_busy && (m_issued < FRAME) && !m_stopped && !pause;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_stopped = 0; m_pend = 0; m_fv = 0;
            m_issued = 0; m_fin = 0; m_last = 0; m_pend_addr = 0;
            m_err = 0; m_fa = 0; m_pl = '0;
        end else begin
            m_en = exp_rd_en();
            if (m_busy && m_fin == 1) begin
                m_busy = 0;
            end else if (!m_busy && start) begin
                m_busy = 1; m_issued = 0; m_fin = 0; m_stopped = 0;
                m_err = 0; m_fv = 0; m_fa = 0; m_pl = '0;
            end else if (m_busy && (m_issued == FRAME || m_stopped)) begin
                m_fin++;
            end
            if (m_pend && mem_a[m_pend_addr] != mem_b[m_pend_addr]) begin
                if (m_err < (1 << AW) - 1) m_err++;
                if (!m_fv) begin
                    m_fv = 1;
                    m_fa = m_pend_addr;
                end
                m_pl[plane_of(m_pend_addr)] = 1'b1;
`ifdef YUV_CMP_EARLY_STOP_EN
                m_stopped = 1;
`endif
            end
            m_pend = m_en;
            if (m_en) begin
                m_pend_addr = m_issued;
                m_last      = m_issued;
                m_issued++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy",      32'(busy),           32'(m_busy));
            check("done",      32'(done),           32'(m_busy && m_fin == 1));
            check("rd_en",     32'(rd_en),          32'(exp_rd_en()));
            check("rd_addr",   32'(rd_addr),        32'(exp_rd_en() ? m_issued : m_last));
            check("err_cnt",   32'(err_cnt),        32'(m_err));
            check("first_vld", 32'(first_err_vld),  32'(m_fv));
            check("first_adr", 32'(first_err_addr), 32'(m_fa));
            check("plane_err", 32'(plane_err),      32'(m_pl));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill_same();
        for (int i = 0; i < FRAME; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = mem_a[i];
        end
    endtask

    task automatic poke(input int a);
        mem_b[a] = ~mem_a[a];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; that cycle is the start cycle (cycle 0).
    task automatic run_frame(input int pause_at, input int pause_len, input int extra_at,
                             input bit rnd, output int done_cyc, output int n_issue,
                             output int first_addr, output int last_addr);
        int cyc;
        cyc = 0; done_cyc = -1; n_issue = 0; first_addr = -1; last_addr = -1;
        start = 1'b1;
        pause = (cyc >= pause_at && cyc < pause_at + pause_len);
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            if (rd_en) begin
                if (first_addr < 0) first_addr = int'(rd_addr);
                last_addr = int'(rd_addr);
                n_issue++;
            end
            if (done) done_cyc = cyc;
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == extra_at);
            pause = rnd ? ($urandom_range(0, 3) == 0)
                        : (cyc >= pause_at && cyc < pause_at + pause_len);
        end
        start = 1'b0;
        pause = 1'b0;
        if (done_cyc < 0) check("run_timeout", 32'd0, 32'd1);
    endtask

    int dc, ni, fa, la, done_seen;

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err",  32'(err_cnt), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        idle(2);
        rst_n = 1'b1;

        // 1: identical frames, with a second start mid-run that must be ignored
        fill_same();
        run_frame(-1, 0, 10, 0, dc, ni, fa, la);
        check("t1_done_cyc", 32'(dc), 32'd50);
        check("t1_issues",   32'(ni), 32'd48);
        check("t1_first",    32'(fa), 32'd0);
        check("t1_last",     32'(la), 32'd47);
        check("t1_err",      32'(err_cnt), 32'd0);
        check("t1_fv",       32'(first_err_vld), 32'd0);
        check("t1_plane",    32'(plane_err), 32'd0);

        // 2: back-to-back, mismatches in every plane
        fill_same(); poke(5); poke(35); poke(44);
        run_frame(-1, 0, -1, 0, dc, ni, fa, la);
`ifndef YUV_CMP_EARLY_STOP_EN
        check("t2_done_cyc", 32'(dc), 32'd50);
        check("t2_err",      32'(err_cnt), 32'd3);
        check("t2_faddr",    32'(first_err_addr), 32'd5);
        check("t2_plane",    32'(plane_err), 32'b111);
`endif

        // 3: back-to-back identical run: stats must be cleared
        fill_same();
        run_frame(-1, 0, -1, 0, dc, ni, fa, la);
        check("t3_err",   32'(err_cnt), 32'd0);
        check("t3_plane", 32'(plane_err), 32'd0);
        idle(3);

        // 4: last byte differs, 10-cycle pause mid-run
        fill_same(); poke(47);
        run_frame(20, 10, -1, 0, dc, ni, fa, la);
        check("t4_done_cyc", 32'(dc), 32'd60);
        check("t4_issues",   32'(ni), 32'd48);
        check("t4_err",      32'(err_cnt), 32'd1);
        check("t4_faddr",    32'(first_err_addr), 32'd47);
        check("t4_plane",    32'(plane_err), 32'b100);
        idle(2);

        // 5: pause high in the start cycle and the two after it
        fill_same();
        run_frame(0, 3, -1, 0, dc, ni, fa, la);
        check("t5_done_cyc", 32'(dc), 32'd52);
        check("t5_first",    32'(fa), 32'd0);
        idle(1);

        // 6: random pause pattern
        fill_same(); poke(3); poke(33); poke(40);
        run_frame(-1, 0, -1, 1, dc, ni, fa, la);
`ifndef YUV_CMP_EARLY_STOP_EN
        check("t6_issues", 32'(ni), 32'd48);
        check("t6_err",    32'(err_cnt), 32'd3);
        check("t6_faddr",  32'(first_err_addr), 32'd3);
        check("t6_plane",  32'(plane_err), 32'b111);
`endif
        idle(2);

        // 7: reset at address 20 aborts with no done, then a clean rescan
        fill_same(); poke(2);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(rd_en && rd_addr == AW'(20)) && n < 100);
            if (n >= 100) check("t7_reach20", 32'd0, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t7_busy",  32'(busy), 32'd0);
        check("t7_rd_en", 32'(rd_en), 32'd0);
        check("t7_addr",  32'(rd_addr), 32'd0);
        check("t7_err",   32'(err_cnt), 32'd0);
        check("t7_fv",    32'(first_err_vld), 32'd0);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t7_no_done", 32'(done_seen), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        run_frame(-1, 0, -1, 0, dc, ni, fa, la);
        check("t7_first",    32'(fa), 32'd0);
        check("t7_done_cyc", 32'(dc), 32'd50);
        check("t7_err",      32'(err_cnt), 32'd1);
        idle(2);

`ifdef YUV_CMP_EARLY_STOP_EN
        // 8: early stop at the first mismatch
        fill_same(); poke(33);
        run_frame(-1, 0, -1, 0, dc, ni, fa, la);
        check("t8_last",  32'(la == 33 || la == 34), 32'd1);
        check("t8_err",   32'(err_cnt), 32'd1);
        check("t8_faddr", 32'(first_err_addr), 32'd33);
        check("t8_plane", 32'(plane_err), 32'b010);
        idle(2);
`endif

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
